demux2_buf: RTL and testbench
=============================

DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, per-output buffer depth; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word present.
REQ-006 SHALL have port in_ready, output, 1, word accepted this cycle if in_valid is also high.
REQ-007 SHALL have port in_data, input, WIDTH, upstream word.
REQ-008 SHALL have port in_sel, input, 1, destination: 0 routes to port 0, 1 routes to port 1.
REQ-009 SHALL have ports out_valid0/out_valid1, output, 1 each, buffered word available on that port.
REQ-010 SHALL have ports out_ready0/out_ready1, input, 1 each, downstream accepts the word on that port.
REQ-011 SHALL have ports out_data0/out_data1, output, WIDTH each, head word of that port's buffer.
REQ-012 SHALL have ports cnt0/cnt1, output, 8 each, count of words delivered on that port.

Function
REQ-013 SHALL accept an input word only on a handshake cycle, in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready = NOT full(buffer[in_sel]), combinationally; there is no bypass when that buffer is full.
REQ-015 SHALL write an accepted word into buffer[in_sel] at the clock edge; the word is visible on out_data of that port no earlier than the next cycle (1-cycle minimum latency).
REQ-016 SHALL drive out_validk = NOT empty(buffer k) and out_datak = head of buffer k, both from registered state.
REQ-017 SHALL pop buffer k on out_validk=1 and out_readyk=1.
REQ-018 SHALL hold out_datak stable while out_validk=1 and out_readyk=0.
REQ-019 SHALL preserve per-port FIFO order; no ordering is guaranteed between the two ports.
REQ-020 SHALL perform a push and a pop on the same buffer in the same cycle when not full, leaving occupancy unchanged with order preserved.
REQ-021 SHALL allow a push to one port and a pop from the other port in the same cycle, independently.
REQ-022 SHALL stall the input (head-of-line blocking) when buffer[in_sel] is full, even if the other buffer has space.
REQ-023 SHALL track occupancy 0..DEPTH per buffer with wrapping read and write pointers of log2(DEPTH) bits each; full = DEPTH and empty = 0.
REQ-024 SHALL increment cntk by 1 on each pop from port k, wrapping 255 -> 0.
REQ-025 SHALL never push while full and never pop while empty, whatever the upstream or downstream signal values.
REQ-026 Upstream SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the bench checks this and the block does not detect violations.

Reset
REQ-027 SHALL, on any clock edge with reset=1, empty both buffers, set both pointers to 0, set out_valid0=out_valid1=0, and set cnt0=cnt1=0.
REQ-028 SHALL drive in_ready=0 while reset=1.
REQ-029 SHALL discard any in-flight or buffered word on reset mid-operation; no handshake during a reset cycle takes effect.
REQ-030 SHALL make out_data0/out_data1 don't-care while the matching out_valid is 0.

Structure
REQ-031 SHALL place the default WIDTH and DEPTH constants and the port-index type (1-bit, PORT0/PORT1) in shared package demux2_pkg.
REQ-032 SHALL implement each buffer as one instance of sub-module fifo_sync (push/pop/full/empty/head), instantiated twice.
REQ-033 SHALL keep the routing logic and in_ready generation in demux2_buf, outside fifo_sync.

Verification
REQ-034 Send in_sel=0 with data 4'hA, then in_sel=1 with data 4'h5, both out_ready=1 -> out_data0=A, then out_data1=5, each valid 1 cycle after acceptance; cnt0=cnt1=1.
REQ-035 Hold out_ready0=0 and push 3,4,7 to port 0 -> 3 and 4 accepted, in_ready=0 on the 7; release ready -> 3,4,7 in order, cnt0=3.
REQ-036 Fill port 0 (out_ready0=0) then present in_sel=0 -> stall while port 1 stays idle; switch to a fresh in_sel=1 word only after acceptance -> verifies head-of-line blocking.
REQ-037 Keep port 1 at one entry, with push and pop every cycle for 10 cycles -> occupancy stays 1, in_ready stays 1, data in order.
REQ-038 Deliver 256 words on port 1 -> cnt1 wraps to 0; assert reset with port 0 holding 2 words -> next cycle out_valid0=0, cnt0=0, in_ready=0 during reset.

Source files
------------

// File: rtl/demux2_pkg.sv
// demux2_pkg: shared defaults and port-index type for the two-way buffered demux.
package demux2_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 2;
    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;
endpackage

// File: rtl/demux2_buf_if.sv
// demux2_buf_if: upstream handshake, two downstream handshakes and delivery counters.
interface demux2_buf_if import demux2_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out_valid0;
    logic             out_valid1;
    logic             out_ready0;
    logic             out_ready1;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    modport master (
        output in_valid, in_data, in_sel, out_ready0, out_ready1,
        input  in_ready, out_valid0, out_valid1, out_data0, out_data1, cnt0, cnt1
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready0, out_ready1,
        output in_ready, out_valid0, out_valid1, out_data0, out_data1, cnt0, cnt1
    );
endinterface

// File: rtl/demux2_buf_fifo.sv
// fifo_sync: synchronous FIFO with wrapping pointers and a 0..DEPTH occupancy count.
module fifo_sync #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    // guards make overflow and underflow impossible regardless of caller behaviour
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: routes each accepted word into one of two FIFOs and counts deliveries per port.
module demux2_buf import demux2_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    demux2_buf_if.slave bus
);
    port_t      sel;
    logic       full0, full1, empty0, empty1;
    logic       hs, push0, push1, pop0, pop1;
    logic [7:0] cnt0, cnt1;
    assign sel  = port_t'(bus.in_sel);
    // readiness follows only the selected buffer, so a full target blocks the line
    assign bus.in_ready = !reset && !(sel == PORT1 ? full1 : full0);
    assign hs    = bus.in_valid && bus.in_ready;
    assign push0 = hs && sel == PORT0;
    assign push1 = hs && sel == PORT1;
    assign pop0  = bus.out_valid0 && bus.out_ready0;
    assign pop1  = bus.out_valid1 && bus.out_ready1;
    assign bus.out_valid0 = !empty0;
    assign bus.out_valid1 = !empty1;
    assign bus.cnt0 = cnt0;
    assign bus.cnt1 = cnt1;
    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push0), .pop(pop0), .din(bus.in_data),
        .head(bus.out_data0), .full(full0), .empty(empty0)
    );
    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push1), .pop(pop1), .din(bus.in_data),
        .head(bus.out_data1), .full(full1), .empty(empty1)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + 8'(pop0);
            cnt1 <= cnt1 + 8'(pop1);
        end
    end
endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: vector table plus directed sequences for stalls, wrap and mid-run reset.
module tb_demux2_buf;
    logic clk = 1'b0;
    logic reset;
    int   nchk = 0;
    int   nerr = 0;

    demux2_buf_if #(.WIDTH(4)) bus ();
    demux2_buf #(.WIDTH(4), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, iv, sel;
        logic [3:0] d;
        logic       r0, r1, e_ir, e_v0;
        logic [3:0] e_d0;
        logic       e_v1;
        logic [3:0] e_d1;
        logic [7:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rst, int iv, int sel, int d, int r0, int r1,
                                int ir, int v0, int d0, int v1, int d1, int c0, int c1);
        vec_t v;
        v = '{rst: 1'(rst), iv: 1'(iv), sel: 1'(sel), d: 4'(d), r0: 1'(r0), r1: 1'(r1),
              e_ir: 1'(ir), e_v0: 1'(v0), e_d0: 4'(d0), e_v1: 1'(v1), e_d1: 4'(d1),
              e_c0: 8'(c0), e_c1: 8'(c1)};
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    // call at a falling edge; returns at the falling edge after the handshake
    task automatic send(input logic s, input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        for (int t = 0; t <= 20; t++) begin
            #1;
            if (bus.in_ready) break;
            if (t == 20) begin
                nchk++;
                nerr++;
                $display("FAIL send_timeout: in_ready got 0, expected 1 within 20 cycles");
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int t = 0; t <= 20; t++) begin
            #1;
            if (bus.in_ready) break;
            if (t == 20) begin
                nchk++;
                nerr++;
                $display("FAIL ready_timeout: in_ready got 0, expected 1 within 20 cycles");
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time got 200000, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b0;
        bus.in_data = '0;
        bus.out_ready0 = 1'b1;
        bus.out_ready1 = 1'b1;
        // basic routing, then a reset, then backpressure on port 0
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,4'hA,1,1, 1,0,0,   0,0,   0,0));
        tbl.push_back(mk(0,1,1,4'h5,1,1, 1,1,4'hA,0,0,   0,0));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   1,4'h5,1,0));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   0,0,   1,1));
        tbl.push_back(mk(1,0,0,0,   1,1, 0,0,0,   0,0,   1,1));
        tbl.push_back(mk(0,1,0,3,   0,1, 1,0,0,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,4,   0,1, 1,1,3,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,7,   0,1, 0,1,3,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,7,   0,1, 0,1,3,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,7,   1,1, 0,1,3,   0,0,   0,0));
        tbl.push_back(mk(0,1,0,7,   1,1, 1,1,4,   0,0,   1,0));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,1,7,   0,0,   2,0));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   0,0,   3,0));
        // steady push+pop on port 1 at occupancy 1
        tbl.push_back(mk(0,1,1,1,   1,1, 1,0,0,   0,0,   3,0));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0,1,1,k+1, 1,1, 1,0,0, 1,k, 3,k-1));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   1,11,  3,10));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,   0,0,   3,11));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            bus.in_valid = tbl[i].iv;
            bus.in_sel = tbl[i].sel;
            bus.in_data = tbl[i].d;
            bus.out_ready0 = tbl[i].r0;
            bus.out_ready1 = tbl[i].r1;
            #1;
            chk($sformatf("v%0d_in_ready", i), bus.in_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_valid0", i), bus.out_valid0, tbl[i].e_v0);
            chk($sformatf("v%0d_valid1", i), bus.out_valid1, tbl[i].e_v1);
            chk($sformatf("v%0d_cnt0", i), bus.cnt0, tbl[i].e_c0);
            chk($sformatf("v%0d_cnt1", i), bus.cnt1, tbl[i].e_c1);
            if (tbl[i].e_v0) chk($sformatf("v%0d_data0", i), bus.out_data0, tbl[i].e_d0);
            if (tbl[i].e_v1) chk($sformatf("v%0d_data1", i), bus.out_data1, tbl[i].e_d1);
            @(negedge clk);
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;

        // head-of-line blocking: port 0 full stalls a port-0 word while port 1 idles
        bus.out_ready0 = 1'b0;
        bus.out_ready1 = 1'b1;
        send(1'b0, 4'h8);
        send(1'b0, 4'h9);
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        bus.in_data = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hol_stall", bus.in_ready, 1'b0);
            chk("hol_port1_idle", bus.out_valid1, 1'b0);
            chk("hol_head", bus.out_data0, 4'h8);
            @(negedge clk);
        end
        bus.out_ready0 = 1'b1;
        #1;
        chk("hol_still_full", bus.in_ready, 1'b0);
        chk("hol_head_first", bus.out_data0, 4'h8);
        @(negedge clk);
        wait_ready();
        chk("hol_head_second", bus.out_data0, 4'h9);
        @(negedge clk);
        bus.in_sel = 1'b1;
        bus.in_data = 4'hC;
        #1;
        chk("hol_switch_ready", bus.in_ready, 1'b1);
        chk("hol_head_third_valid", bus.out_valid0, 1'b1);
        chk("hol_head_third", bus.out_data0, 4'h6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("hol_port0_drained", bus.out_valid0, 1'b0);
        chk("hol_port1_valid", bus.out_valid1, 1'b1);
        chk("hol_port1_data", bus.out_data1, 4'hC);
        @(negedge clk);

        // 256 deliveries on port 1 wrap its counter
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel = 1'b1;
            bus.in_data = 4'(i);
            #1;
            chk("wrap_ready", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("wrap_last_valid", bus.out_valid1, 1'b1);
        chk("wrap_last_data", bus.out_data1, 4'hF);
        chk("wrap_cnt_255", bus.cnt1, 8'd255);
        @(negedge clk);
        #1;
        chk("wrap_cnt_0", bus.cnt1, 8'd0);
        chk("wrap_empty", bus.out_valid1, 1'b0);
        @(negedge clk);

        // reset with two words buffered on port 0 discards them and any handshake
        send(1'b0, 4'h2);
        @(negedge clk);
        bus.out_ready0 = 1'b0;
        send(1'b0, 4'h3);
        send(1'b0, 4'h4);
        #1;
        chk("pre_rst_valid0", bus.out_valid0, 1'b1);
        chk("pre_rst_data0", bus.out_data0, 4'h3);
        chk("pre_rst_cnt0", bus.cnt0, 8'd1);
        chk("pre_rst_full", bus.in_ready, 1'b0);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b1;
        bus.in_data = 4'h9;
        bus.out_ready0 = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_valid0", bus.out_valid0, 1'b0);
        chk("post_rst_valid1", bus.out_valid1, 1'b0);
        chk("post_rst_cnt0", bus.cnt0, 8'd0);
        chk("post_rst_cnt1", bus.cnt1, 8'd0);
        chk("post_rst_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
